io_arbiter: RTL

IO_ARBITER -- requirements
Module: io_arbiter

---
 rtl/io_arb_pkg.sv | 14 +
 rtl/io_arb_pick.sv | 21 ++
 rtl/io_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/io_arb_pkg.sv
// Shared definitions for the IO arbiter: the FSM state encoding and the
// default IO window bounds.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [31:0] DEF_ADDR_LO = 32'h0000_7F50;
    localparam logic [31:0] DEF_ADDR_HI = 32'h0000_7F63;

endpackage

// File: rtl/io_arb_pick.sv
// Grant selection between two masters.
// IO_ARBITER_RR_EN selects round-robin; otherwise fixed priority m0 > m1.
module io_arb_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

`ifdef IO_ARBITER_RR_EN
    // Contested: favour whoever did not win last time; otherwise the lone requester.
    always_comb begin
        if (req == 2'b11) grant = ~last;
        else              grant = ~req[0];
    end
`else
    logic unused_last;
    assign unused_last = last;
    assign grant       = ~req[0];
`endif

endmodule

// File: rtl/io_arbiter.sv
// Two-master arbiter in front of a single IO device window.
// Arbitration policy selected by IO_ARBITER_RR_EN (see io_arb_pick).
module io_arbiter
    import io_arb_pkg::*;
#(
    parameter logic [31:0] ADDR_LO = DEF_ADDR_LO,
    parameter logic [31:0] ADDR_HI = DEF_ADDR_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_byteen,
    input  logic [31:0] s_rdata
);

    state_t            state;
    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_byteen;
    logic              lat_idx;
    logic              last;
    logic [1:0]        ack;
    logic [1:0]        err;
    logic [1:0][31:0]  rdata;
    logic              grant;
    logic              in_win;

    io_arb_pick u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last),
        .grant (grant)
    );

    assign in_win = (lat_addr >= ADDR_LO) && (lat_addr <= ADDR_HI);

    // Strobe is a decode of the registered state, so it lasts exactly the ACCESS cycle.
    assign s_addr   = lat_addr;
    assign s_wdata  = lat_wdata;
    assign s_byteen = (state == ACCESS && lat_we && in_win) ? lat_byteen : 4'b0000;

    assign m0_ack   = ack[0];
    assign m1_ack   = ack[1];
    assign m0_err   = err[0];
    assign m1_err   = err[1];
    assign m0_rdata = rdata[0];
    assign m1_rdata = rdata[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_byteen <= 4'd0;
            lat_idx    <= 1'b0;
            last       <= 1'b1;
            ack        <= 2'b00;
            err        <= 2'b00;
            rdata      <= '0;
        end else begin
            ack <= 2'b00;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        lat_we     <= grant ? m1_we     : m0_we;
                        lat_addr   <= grant ? m1_addr   : m0_addr;
                        lat_wdata  <= grant ? m1_wdata  : m0_wdata;
                        lat_byteen <= grant ? m1_byteen : m0_byteen;
                        lat_idx    <= grant;
`ifdef IO_ARBITER_RR_EN
                        last       <= grant;
`endif
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata[lat_idx] <= (lat_we || !in_win) ? 32'd0 : s_rdata;
                    err[lat_idx]   <= !in_win;
                    ack[lat_idx]   <= 1'b1;
                    state          <= ACK;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
